// File: rtl/dmem_access_pkg.sv
// Shared definitions for the data-memory access unit: FSM encoding and timeout default.
package dmem_access_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int TIMEOUT_CYC_DEFAULT = 16;
  localparam int CNT_W               = 8;

endpackage

// File: rtl/dmem_timeout_cnt.sv
// Cycle counter for a memory access in flight; tc_o flags the last allowed cycle.
module dmem_timeout_cnt
  import dmem_access_pkg::*;
#(
  parameter int TERM = TIMEOUT_CYC_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic tc_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TERM - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt <= '0;
    end else if (clear_i) begin
      cnt <= '0;
    end else if (enable_i) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tc_o = (cnt == LAST);

endmodule

// File: rtl/dmem_access.sv
// MEM-stage data memory sequencer: captures one load/store, drives the external
// request until ack or timeout, and stalls the pipeline while the access is open.
module dmem_access
  import dmem_access_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] Addr_i,
  input  logic [31:0] WriteData_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] ReadData_o,
  output logic        stall_o,
  output logic        error_o,
  output logic [1:0]  dbgState_o
);

  // Memory handshake: mem_req_o stays high with stable we/addr/wdata from the
  // first BUSY cycle until the cycle in which mem_ack_i is sampled high; rdata
  // is only consumed in that ack cycle, and ack outside BUSY is ignored.

  state_t      state;
  logic        weQ;
  logic [31:0] addrQ;
  logic [31:0] wdataQ;
  logic [31:0] readDataQ;
  logic        errorQ;

  logic accessReq;
  logic busy;
  logic timeout;

  assign accessReq = start_i && (MemRead_i || MemWrite_i);
  assign busy      = (state == BUSY);

  dmem_timeout_cnt #(
    .TERM(TIMEOUT_CYC)
  ) u_timeout (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (!busy),
    .enable_i(busy && !mem_ack_i),
    .tc_o    (timeout)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= IDLE;
      weQ       <= 1'b0;
      addrQ     <= '0;
      wdataQ    <= '0;
      readDataQ <= '0;
      errorQ    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accessReq) begin
            addrQ  <= Addr_i;
            wdataQ <= WriteData_i;
            weQ    <= MemWrite_i;
            // Misaligned word access never reaches memory.
            if (Addr_i[1:0] == 2'b00) begin
              state <= BUSY;
            end else begin
              state  <= DONE;
              errorQ <= 1'b1;
            end
          end
        end
        BUSY: begin
          // Ack is checked first so a reply in the last allowed cycle still counts.
          if (mem_ack_i) begin
            if (!weQ) readDataQ <= mem_rdata_i;
            state <= DONE;
          end else if (timeout) begin
            if (!weQ) readDataQ <= '0;
            errorQ <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign mem_req_o   = busy;
  assign mem_we_o    = busy && weQ;
  assign mem_addr_o  = busy ? addrQ  : '0;
  assign mem_wdata_o = busy ? wdataQ : '0;

  // DONE releases the pipeline so the finished instruction advances out of MEM.
  assign stall_o     = rst_i && (busy || ((state == IDLE) && accessReq));

  assign ReadData_o  = readDataQ;
  assign error_o     = errorQ;
  assign dbgState_o  = state;

endmodule

// File: tb/tb_dmem_access.sv
// Randomized scoreboard bench for dmem_access with a transaction-level reference model.
module tb_dmem_access;
  import dmem_access_pkg::*;

  localparam int TO = 16;

  // ---------------- clock / reset ----------------
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        MemRead_i;
  logic        MemWrite_i;
  logic [31:0] Addr_i;
  logic [31:0] WriteData_i;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic [31:0] ReadData_o;
  logic        stall_o;
  logic        error_o;
  logic [1:0]  dbgState_o;

  always #5 clk_i = ~clk_i;

  dmem_access #(.TIMEOUT_CYC(TO)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .MemRead_i  (MemRead_i),
    .MemWrite_i (MemWrite_i),
    .Addr_i     (Addr_i),
    .WriteData_i(WriteData_i),
    .mem_req_o  (mem_req_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_ack_i  (mem_ack_i),
    .mem_rdata_i(mem_rdata_i),
    .ReadData_o (ReadData_o),
    .stall_o    (stall_o),
    .error_o    (error_o),
    .dbgState_o (dbgState_o)
  );

  // ---------------- scoreboard state ----------------
  int          vecs = 0;
  int          errs = 0;
  logic [64:0] exp_q[$];   // {we, addr, wdata} per expected memory request
  logic [40:0] done_q[$];  // {ReadData, error, stall cycles} per completion
  logic [31:0] rdM = '0;
  logic        errM = 1'b0;
  int          reqSeen = 0;
  int          reqExp = 0;

  int          curAckAt = 0;
  logic [31:0] curRdata = '0;
  logic        forceAck = 1'b0;
  int          busyIdx = 0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  always @(negedge clk_i) begin
    if (mem_req_o) busyIdx++;
    else busyIdx = 0;
    mem_ack_i   = forceAck || (mem_req_o && (busyIdx == curAckAt));
    mem_rdata_i = curRdata;
  end

  // ---------------- monitor ----------------
  logic [64:0] curReq = '0;
  logic        prevReq = 1'b0;
  int          stallCnt = 0;
  logic [40:0] doneExp;

  always @(negedge clk_i) begin
    #2;
    if (!rst_i) begin
      stallCnt = 0;
      prevReq  = 1'b0;
    end else begin
      if (stall_o) stallCnt++;
      if (mem_req_o && !prevReq) begin
        reqSeen++;
        if (exp_q.size() == 0) begin
          vecs++;
          errs++;
          $display("FAIL req_unexpected: got request to %0h expected none", mem_addr_o);
          curReq = '0;
        end else begin
          curReq = exp_q.pop_front();
        end
      end
      if (mem_req_o) check("mem_bus", 72'({mem_we_o, mem_addr_o, mem_wdata_o}), 72'(curReq));
      else check("mem_bus_idle", 72'({mem_we_o, mem_addr_o, mem_wdata_o}), 72'(0));
      prevReq = mem_req_o;
      if (dbgState_o == DONE) begin
        if (done_q.size() == 0) begin
          vecs++;
          errs++;
          $display("FAIL done_unexpected: got completion expected none at %0t", $time);
        end else begin
          doneExp = done_q.pop_front();
          check("done_rdata", 72'(ReadData_o), 72'(doneExp[40:9]));
          check("done_error", 72'(error_o), 72'(doneExp[8]));
          check("done_stall", 72'(stallCnt), 72'(doneExp[7:0]));
        end
        stallCnt = 0;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input int ackAt, input bit hold);
    bit aligned;
    int stall;
    int n;
    aligned = (addr[1:0] == 2'b00);
    if (!aligned) begin
      errM  = 1'b1;
      stall = 1;
    end else begin
      exp_q.push_back({wr, addr, wdata});
      reqExp++;
      if (ackAt >= 1 && ackAt <= TO) begin
        stall = ackAt + 1;
        if (!wr) rdM = rdata;
      end else begin
        stall = TO + 1;
        errM  = 1'b1;
        if (!wr) rdM = '0;
      end
    end
    done_q.push_back({rdM, errM, 8'(stall)});
    curAckAt    = ackAt;
    curRdata    = rdata;
    start_i     = 1'b1;
    MemRead_i   = rd;
    MemWrite_i  = wr;
    Addr_i      = addr;
    WriteData_i = wdata;
    @(negedge clk_i);
    if (!hold) begin
      start_i     = 1'b0;
      MemRead_i   = 1'b0;
      MemWrite_i  = 1'b0;
      Addr_i      = $urandom;
      WriteData_i = $urandom;
    end
    n = 0;
    while (dbgState_o != DONE && n < 64) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 64) begin
      vecs++;
      errs++;
      $display("FAIL done_wait: got no completion expected one within 64 cycles");
    end
    @(negedge clk_i);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic rd;
    logic wr;
    logic [31:0] a;
    rst_i       = 1'b0;
    start_i     = 1'b1;
    MemRead_i   = 1'b1;
    MemWrite_i  = 1'b0;
    Addr_i      = 32'h10;
    WriteData_i = '0;
    repeat (2) @(negedge clk_i);
    #1;
    check("rst_stall", 72'(stall_o), 72'(0));
    check("rst_req", 72'(mem_req_o), 72'(0));
    check("rst_error", 72'(error_o), 72'(0));
    check("rst_rdata", 72'(ReadData_o), 72'(0));
    check("rst_state", 72'(dbgState_o), 72'(0));
    start_i   = 1'b0;
    MemRead_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);

    do_access(1'b0, 1'b1, 32'h20, 32'h12345678, $urandom, 1, 1'b0);
    do_access(1'b1, 1'b0, 32'h10, $urandom, 32'hDEADBEEF, 3, 1'b0);
    do_access(1'b1, 1'b1, 32'h24, 32'hA5A5A5A5, $urandom, 2, 1'b0);
    do_access(1'b1, 1'b0, 32'h30, $urandom, 32'hCAFEF00D, TO, 1'b0);
    for (int i = 0; i < 20; i++) begin
      rd = 1'($urandom_range(0, 1));
      wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      do_access(rd, wr, $urandom & 32'hFFFF_FFFC, $urandom, $urandom,
                $urandom_range(1, 6), 1'b0);
    end

    do_access(1'b1, 1'b0, 32'h22, $urandom, $urandom, 1, 1'b0);
    do_access(1'b1, 1'b0, 32'h40, $urandom, $urandom, 0, 1'b0);

    // Reset in the second BUSY cycle, then a stray ack after release.
    curAckAt    = 0;
    start_i     = 1'b1;
    MemRead_i   = 1'b1;
    MemWrite_i  = 1'b0;
    Addr_i      = 32'h50;
    WriteData_i = 32'h0BAD0BAD;
    exp_q.push_back({1'b0, 32'h50, 32'h0BAD0BAD});
    reqExp++;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check("midrst_req", 72'(mem_req_o), 72'(0));
    check("midrst_stall", 72'(stall_o), 72'(0));
    check("midrst_error", 72'(error_o), 72'(0));
    check("midrst_rdata", 72'(ReadData_o), 72'(0));
    check("midrst_state", 72'(dbgState_o), 72'(0));
    errM      = 1'b0;
    rdM       = '0;
    start_i   = 1'b0;
    MemRead_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    curRdata = 32'h11112222;
    forceAck = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    forceAck = 1'b0;
    @(negedge clk_i);
    #1;
    check("lateack_rdata", 72'(ReadData_o), 72'(0));
    check("lateack_state", 72'(dbgState_o), 72'(0));
    check("lateack_error", 72'(error_o), 72'(0));
    @(negedge clk_i);

    // Back-to-back reads with the request held on the inputs through DONE.
    do_access(1'b1, 1'b0, 32'h60, 32'h1, 32'h600DF00D, 2, 1'b1);
    do_access(1'b1, 1'b0, 32'h60, 32'h1, 32'h13572468, 1, 1'b1);
    do_access(1'b1, 1'b0, 32'h60, 32'h1, 32'h2468ACE0, 4, 1'b0);

    for (int i = 0; i < 30; i++) begin
      rd = 1'($urandom_range(0, 1));
      wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      do_access(rd, wr, a, $urandom, $urandom, $urandom_range(0, 20), 1'b0);
    end

    repeat (3) @(negedge clk_i);
    check("req_count", 72'(reqSeen), 72'(reqExp));
    check("req_queue_empty", 72'(exp_q.size()), 72'(0));
    check("done_queue_empty", 72'(done_q.size()), 72'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
